// File: rtl/pipe_pkg.sv
// Shared definitions for the 19-bit in-order pipeline: widths, opcodes,
// instruction field positions, immediate helpers and stage payload types.
package pipe_pkg;

  localparam int XLEN = 19;
  localparam int NREG = 8;
  localparam int RIDX = 3;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_ADDI = 5'd8;
  localparam logic [4:0] OP_LW   = 5'd16;
  localparam logic [4:0] OP_SW   = 5'd17;
  localparam logic [4:0] OP_BEQ  = 5'd24;
  localparam logic [4:0] OP_BNE  = 5'd25;
  localparam logic [4:0] OP_JAL  = 5'd28;
  localparam logic [4:0] OP_ACC  = 5'd31;

  localparam int OP_HI    = 18;
  localparam int OP_LO    = 14;
  localparam int FA_HI    = 13;
  localparam int FA_LO    = 11;
  localparam int FB_HI    = 10;
  localparam int FB_LO    = 8;
  localparam int FC_HI    = 7;
  localparam int FC_LO    = 5;
  localparam int IMM8_HI  = 7;
  localparam int OFF11_HI = 10;

  typedef struct packed {
    logic            legal;
    logic [RIDX-1:0] rd;
    logic [RIDX-1:0] rs1;
    logic [RIDX-1:0] rs2;
    logic            use1;
    logic            use2;
    logic [XLEN-1:0] imm;
    logic            reg_we;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
  } dec_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      op;
    logic [RIDX-1:0] rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            reg_we;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
  } idex_t;

  function automatic logic [XLEN-1:0] sext8(input logic [7:0] v);
    return {{(XLEN-8){v[7]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext11(input logic [10:0] v);
    return {{(XLEN-11){v[10]}}, v};
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch, write-back and ID/EX signal bundle around the decode stage.
// The slave side is the decode stage itself; the master side is its environment.
interface id_stage_if;
  import pipe_pkg::*;

  logic            stall_in;
  logic            flush;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            wb_we;
  logic [RIDX-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            hazard_stall;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      id_op;
  logic [RIDX-1:0] id_rd;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic            id_reg_we;
  logic            id_is_load;
  logic            id_is_store;
  logic            id_is_branch;
  logic            illegal;

  modport master (
    output stall_in, flush, if_valid, if_pc, if_instr, wb_we, wb_rd, wb_data,
    input  hazard_stall, id_valid, id_pc, id_op, id_rd, id_rs1_data, id_rs2_data,
           id_imm, id_reg_we, id_is_load, id_is_store, id_is_branch, illegal
  );

  modport slave (
    input  stall_in, flush, if_valid, if_pc, if_instr, wb_we, wb_rd, wb_data,
    output hazard_stall, id_valid, id_pc, id_op, id_rd, id_rs1_data, id_rs2_data,
           id_imm, id_reg_we, id_is_load, id_is_store, id_is_branch, illegal
  );

endinterface

// File: rtl/id_regfile.sv
// 8x19 register file: one write port, two combinational read ports with
// write-first bypass; r0 always reads zero and is never written.
module id_regfile
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [RIDX-1:0] wa_i,
  input  logic [XLEN-1:0] wd_i,
  input  logic [RIDX-1:0] ra1_i,
  input  logic [RIDX-1:0] ra2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o
);

  logic [XLEN-1:0] mem_q [NREG];

  // register array write, cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (wa_i != '0)) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // read port 1 with same-cycle write-back forwarding
  always_comb begin
    if (ra1_i == '0) begin
      rd1_o = '0;
    end else if (we_i && (wa_i == ra1_i)) begin
      rd1_o = wd_i;
    end else begin
      rd1_o = mem_q[ra1_i];
    end
  end

  // read port 2 with same-cycle write-back forwarding
  always_comb begin
    if (ra2_i == '0) begin
      rd2_o = '0;
    end else if (we_i && (wa_i == ra2_i)) begin
      rd2_o = wd_i;
    end else begin
      rd2_o = mem_q[ra2_i];
    end
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: instruction decode, register read with bypass, load-use
// hazard detection and the ID/EX pipeline register.
module id_stage
  import pipe_pkg::*;
(
  input logic     clk,
  input logic     rst_n,
  id_stage_if.slave bus
);

  logic [4:0]      op_s;
  logic [RIDX-1:0] fa_s;
  logic [RIDX-1:0] fb_s;
  logic [RIDX-1:0] fc_s;
  dec_t            dec_s;
  logic [XLEN-1:0] rs1_data_s;
  logic [XLEN-1:0] rs2_data_s;
  logic            hazard_s;
  logic            live_s;
  idex_t           idex_d;
  idex_t           idex_q;
  logic            illegal_d;
  logic            illegal_q;

  assign op_s = bus.if_instr[OP_HI:OP_LO];
  assign fa_s = bus.if_instr[FA_HI:FA_LO];
  assign fb_s = bus.if_instr[FB_HI:FB_LO];
  assign fc_s = bus.if_instr[FC_HI:FC_LO];

  // opcode decode; unused source indices stay 0 so they read as zero
  always_comb begin
    dec_s = '0;
    case (op_s)
      OP_NOP: begin
        dec_s.legal = 1'b1;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ACC: begin
        dec_s.legal  = 1'b1;
        dec_s.rd     = fa_s;
        dec_s.rs1    = fb_s;
        dec_s.rs2    = fc_s;
        dec_s.use1   = 1'b1;
        dec_s.use2   = 1'b1;
        dec_s.reg_we = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        dec_s.legal   = 1'b1;
        dec_s.rd      = fa_s;
        dec_s.rs1     = fb_s;
        dec_s.use1    = 1'b1;
        dec_s.imm     = sext8(bus.if_instr[IMM8_HI:0]);
        dec_s.reg_we  = 1'b1;
        dec_s.is_load = (op_s == OP_LW);
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        dec_s.legal     = 1'b1;
        dec_s.rs1       = fb_s;
        dec_s.rs2       = fa_s;
        dec_s.use1      = 1'b1;
        dec_s.use2      = 1'b1;
        dec_s.imm       = sext8(bus.if_instr[IMM8_HI:0]);
        dec_s.is_store  = (op_s == OP_SW);
        dec_s.is_branch = (op_s != OP_SW);
      end
      OP_JAL: begin
        dec_s.legal     = 1'b1;
        dec_s.rd        = fa_s;
        dec_s.imm       = sext11(bus.if_instr[OFF11_HI:0]);
        dec_s.reg_we    = 1'b1;
        dec_s.is_branch = 1'b1;
      end
      default: begin
        dec_s.legal = 1'b0;
      end
    endcase
  end

  id_regfile u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we_i  (bus.wb_we),
    .wa_i  (bus.wb_rd),
    .wd_i  (bus.wb_data),
    .ra1_i (dec_s.rs1),
    .ra2_i (dec_s.rs2),
    .rd1_o (rs1_data_s),
    .rd2_o (rs2_data_s)
  );

  // a load already in ID/EX cannot forward its data to the instruction behind it
  assign hazard_s = bus.if_valid & idex_q.valid & idex_q.is_load & (idex_q.rd != '0) &
                    ((dec_s.use1 & (dec_s.rs1 == idex_q.rd)) |
                     (dec_s.use2 & (dec_s.rs2 == idex_q.rd)));

  assign live_s    = bus.if_valid & dec_s.legal;
  assign illegal_d = bus.if_valid & ~bus.flush & ~dec_s.legal;

  // ID/EX next state: flush beats stall beats hazard bubble beats normal load
  always_comb begin
    idex_d = idex_q;
    if (bus.flush) begin
      idex_d.valid     = 1'b0;
      idex_d.reg_we    = 1'b0;
      idex_d.is_load   = 1'b0;
      idex_d.is_store  = 1'b0;
      idex_d.is_branch = 1'b0;
    end else if (bus.stall_in) begin
      idex_d = idex_q;
    end else if (hazard_s) begin
      idex_d.valid     = 1'b0;
      idex_d.reg_we    = 1'b0;
      idex_d.is_load   = 1'b0;
      idex_d.is_store  = 1'b0;
      idex_d.is_branch = 1'b0;
    end else begin
      idex_d.valid     = live_s;
      idex_d.pc        = bus.if_pc;
      idex_d.op        = op_s;
      idex_d.rd        = dec_s.rd;
      idex_d.rs1_data  = rs1_data_s;
      idex_d.rs2_data  = rs2_data_s;
      idex_d.imm       = dec_s.imm;
      idex_d.reg_we    = live_s & dec_s.reg_we;
      idex_d.is_load   = live_s & dec_s.is_load;
      idex_d.is_store  = live_s & dec_s.is_store;
      idex_d.is_branch = live_s & dec_s.is_branch;
    end
  end

  // ID/EX pipeline register and illegal-opcode pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      idex_q    <= idex_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.hazard_stall = hazard_s;
  assign bus.id_valid     = idex_q.valid;
  assign bus.id_pc        = idex_q.pc;
  assign bus.id_op        = idex_q.op;
  assign bus.id_rd        = idex_q.rd;
  assign bus.id_rs1_data  = idex_q.rs1_data;
  assign bus.id_rs2_data  = idex_q.rs2_data;
  assign bus.id_imm       = idex_q.imm;
  assign bus.id_reg_we    = idex_q.reg_we;
  assign bus.id_is_load   = idex_q.is_load;
  assign bus.id_is_store  = idex_q.is_store;
  assign bus.id_is_branch = idex_q.is_branch;
  assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: decode table, hand-written corner
// sequences and randomized traffic against a behavioural model.
module tb_id_stage;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_stage_if bus ();
  id_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [18:0] rf [8];
  typedef struct {
    bit          valid;
    logic [18:0] pc;
    logic [4:0]  op;
    logic [2:0]  rd;
    logic [18:0] r1, r2, imm;
    bit          we, ld, st, br, ill;
  } exp_t;
  exp_t ex;

  typedef struct {
    bit legal; int rd; bit u1, u2; int s1, s2; int imm; bit we, ld, st, br;
  } mdec_t;

  typedef struct {
    bit iv; logic [18:0] instr;
    bit ev; logic [2:0] erd; logic [18:0] er1, er2, eimm;
    bit ewe, eld, est, ebr, eill;
  } vec_t;
  vec_t tv [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [18:0] enc(input int op, input int a, input int b, input int lo8);
    return 19'((op << 14) | (a << 11) | (b << 8) | (lo8 & 255));
  endfunction

  function automatic mdec_t mdecode(input logic [18:0] ins);
    mdec_t d;
    int op, a, b, c, i8, o11;
    op = int'(ins) >> 14; a = (int'(ins) >> 11) & 7; b = (int'(ins) >> 8) & 7;
    c = (int'(ins) >> 5) & 7; i8 = int'(ins) & 255; o11 = int'(ins) & 2047;
    d = '{default: 0};
    if (op inside {1, 2, 3, 4, 5, 31}) begin
      d.legal = 1; d.rd = a; d.u1 = 1; d.u2 = 1; d.s1 = b; d.s2 = c; d.we = 1;
    end else if (op == 0) begin
      d.legal = 1;
    end else if (op inside {8, 16}) begin
      d.legal = 1; d.rd = a; d.u1 = 1; d.s1 = b; d.we = 1; d.ld = (op == 16);
      d.imm = (i8 >= 128) ? i8 - 256 : i8;
    end else if (op inside {17, 24, 25}) begin
      d.legal = 1; d.u1 = 1; d.u2 = 1; d.s1 = b; d.s2 = a;
      d.st = (op == 17); d.br = (op != 17);
      d.imm = (i8 >= 128) ? i8 - 256 : i8;
    end else if (op == 28) begin
      d.legal = 1; d.rd = a; d.we = 1; d.br = 1;
      d.imm = (o11 >= 1024) ? o11 - 2048 : o11;
    end
    return d;
  endfunction

  function automatic logic [18:0] opnd(input bit used, input int idx);
    if (!used || idx == 0) return 19'd0;
    if (bus.wb_we && int'(bus.wb_rd) == idx) return bus.wb_data;
    return rf[idx];
  endfunction

  task automatic drv(input bit iv, input logic [18:0] ins, input logic [18:0] pc,
                     input bit stall, input bit fl, input bit we, input int wrd,
                     input logic [18:0] wd);
    bus.if_valid = iv; bus.if_instr = ins; bus.if_pc = pc;
    bus.stall_in = stall; bus.flush = fl;
    bus.wb_we = we; bus.wb_rd = 3'(wrd); bus.wb_data = wd;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) rf[i] = 19'd0;
    ex = '{default: 0};
  endtask

  task automatic check_out();
    chk("id_valid", bus.id_valid, ex.valid);
    chk("id_reg_we", bus.id_reg_we, ex.we);
    chk("id_is_load", bus.id_is_load, ex.ld);
    chk("id_is_store", bus.id_is_store, ex.st);
    chk("id_is_branch", bus.id_is_branch, ex.br);
    chk("illegal", bus.illegal, ex.ill);
    if (ex.valid) begin
      chk("id_pc", bus.id_pc, ex.pc);
      chk("id_op", bus.id_op, ex.op);
      chk("id_rd", bus.id_rd, ex.rd);
      chk("id_rs1_data", bus.id_rs1_data, ex.r1);
      chk("id_rs2_data", bus.id_rs2_data, ex.r2);
      chk("id_imm", bus.id_imm, ex.imm);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_hazard"}, bus.hazard_stall, 0);
    chk({tag, "_valid"}, bus.id_valid, 0);
    chk({tag, "_pc"}, bus.id_pc, 0);
    chk({tag, "_op"}, bus.id_op, 0);
    chk({tag, "_rd"}, bus.id_rd, 0);
    chk({tag, "_rs1"}, bus.id_rs1_data, 0);
    chk({tag, "_rs2"}, bus.id_rs2_data, 0);
    chk({tag, "_imm"}, bus.id_imm, 0);
    chk({tag, "_we"}, bus.id_reg_we, 0);
    chk({tag, "_ld"}, bus.id_is_load, 0);
    chk({tag, "_st"}, bus.id_is_store, 0);
    chk({tag, "_br"}, bus.id_is_branch, 0);
    chk({tag, "_ill"}, bus.illegal, 0);
  endtask

  // one clock: check combinational hazard, predict, advance, check registers
  task automatic cycle();
    mdec_t d;
    bit hz;
    exp_t n;
    #1;
    d = mdecode(bus.if_instr);
    hz = bus.if_valid && ex.valid && ex.ld && ex.rd != 0 &&
         ((d.u1 && d.s1 == int'(ex.rd)) || (d.u2 && d.s2 == int'(ex.rd)));
    chk("hazard_stall", bus.hazard_stall, hz);
    n = ex;
    if (bus.flush) begin
      n.valid = 0; n.we = 0; n.ld = 0; n.st = 0; n.br = 0;
    end else if (bus.stall_in) begin
      n = ex;
    end else if (hz) begin
      n.valid = 0; n.we = 0; n.ld = 0; n.st = 0; n.br = 0;
    end else begin
      n.valid = bus.if_valid && d.legal;
      n.pc = bus.if_pc; n.op = bus.if_instr[18:14]; n.rd = 3'(d.rd);
      n.r1 = opnd(d.u1, d.s1); n.r2 = opnd(d.u2, d.s2); n.imm = 19'(d.imm);
      n.we = n.valid && d.we; n.ld = n.valid && d.ld;
      n.st = n.valid && d.st; n.br = n.valid && d.br;
    end
    n.ill = bus.if_valid && !bus.flush && !d.legal;
    @(posedge clk);
    if (bus.wb_we && bus.wb_rd != 3'd0) rf[bus.wb_rd] = bus.wb_data;
    ex = n;
    #1;
    check_out();
  endtask

  initial begin
    logic [18:0] add3;
    int ops [16] = '{0, 1, 2, 3, 4, 5, 8, 16, 17, 24, 25, 28, 31, 6, 7, 9};

    rst_n = 1'b0;
    drv(0, 19'd0, 19'd0, 0, 0, 0, 0, 19'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // preload rK = K * 0x01111
    for (int k = 1; k < 8; k++) begin
      drv(0, 19'd0, 19'd0, 0, 0, 1, k, 19'(k * 32'h01111));
      cycle();
    end

    tv[0]  = '{1, enc(1, 3, 1, 2 << 5), 1, 3'd3, 19'h01111, 19'h02222, 19'h0, 1, 0, 0, 0, 0};
    tv[1]  = '{1, enc(2, 7, 6, 0),      1, 3'd7, 19'h06666, 19'h0, 19'h0, 1, 0, 0, 0, 0};
    tv[2]  = '{1, enc(8, 1, 0, 8'hFD),  1, 3'd1, 19'h0, 19'h0, 19'h7FFFD, 1, 0, 0, 0, 0};
    tv[3]  = '{1, enc(16, 4, 5, 8'h7F), 1, 3'd4, 19'h05555, 19'h0, 19'h0007F, 1, 1, 0, 0, 0};
    tv[4]  = '{1, enc(17, 6, 7, 8'h80), 1, 3'd0, 19'h07777, 19'h06666, 19'h7FF80, 0, 0, 1, 0, 0};
    tv[5]  = '{1, enc(24, 1, 2, 8'h10), 1, 3'd0, 19'h02222, 19'h01111, 19'h00010, 0, 0, 0, 1, 0};
    tv[6]  = '{1, enc(28, 7, 4, 0),     1, 3'd7, 19'h0, 19'h0, 19'h7FC00, 1, 0, 0, 1, 0};
    tv[7]  = '{1, enc(31, 5, 3, 4 << 5), 1, 3'd5, 19'h03333, 19'h04444, 19'h0, 1, 0, 0, 0, 0};
    tv[8]  = '{1, enc(0, 5, 3, 4 << 5), 1, 3'd0, 19'h0, 19'h0, 19'h0, 0, 0, 0, 0, 0};
    tv[9]  = '{1, enc(6, 1, 2, 3),      0, 3'd0, 19'h0, 19'h0, 19'h0, 0, 0, 0, 0, 1};
    tv[10] = '{0, enc(5, 1, 2, 3 << 5), 0, 3'd0, 19'h0, 19'h0, 19'h0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 11; i++) begin
      drv(tv[i].iv, tv[i].instr, 19'(100 + i), 0, 0, 0, 0, 19'd0);
      cycle();
      chk($sformatf("tv%0d_valid", i), bus.id_valid, tv[i].ev);
      chk($sformatf("tv%0d_we", i), bus.id_reg_we, tv[i].ewe);
      chk($sformatf("tv%0d_ld", i), bus.id_is_load, tv[i].eld);
      chk($sformatf("tv%0d_st", i), bus.id_is_store, tv[i].est);
      chk($sformatf("tv%0d_br", i), bus.id_is_branch, tv[i].ebr);
      chk($sformatf("tv%0d_ill", i), bus.illegal, tv[i].eill);
      if (tv[i].ev) begin
        chk($sformatf("tv%0d_rd", i), bus.id_rd, tv[i].erd);
        chk($sformatf("tv%0d_rs1", i), bus.id_rs1_data, tv[i].er1);
        chk($sformatf("tv%0d_rs2", i), bus.id_rs2_data, tv[i].er2);
        chk($sformatf("tv%0d_imm", i), bus.id_imm, tv[i].eimm);
        chk($sformatf("tv%0d_pc", i), bus.id_pc, 19'(100 + i));
      end
    end

    // write-back bypass into both operands
    drv(1, enc(1, 3, 2, 2 << 5), 19'd200, 0, 0, 1, 2, 19'h00123);
    cycle();
    chk("bypass_rs1", bus.id_rs1_data, 19'h00123);
    chk("bypass_rs2", bus.id_rs2_data, 19'h00123);

    // load-use on rs1, then on SW's A field, then a non-dependent ADDI
    drv(1, enc(16, 4, 1, 5), 19'd201, 0, 0, 0, 0, 19'd0);
    cycle();
    drv(1, enc(1, 5, 4, 1 << 5), 19'd202, 0, 0, 0, 0, 19'd0);
    #1 chk("lu_hazard", bus.hazard_stall, 1);
    cycle();
    chk("lu_bubble", bus.id_valid, 0);
    #1 chk("lu_hazard_clear", bus.hazard_stall, 0);
    cycle();
    chk("lu_add_valid", bus.id_valid, 1);
    chk("lu_add_rd", bus.id_rd, 5);
    drv(1, enc(16, 4, 1, 5), 19'd203, 0, 0, 0, 0, 19'd0);
    cycle();
    drv(1, enc(17, 4, 1, 0), 19'd204, 0, 0, 0, 0, 19'd0);
    #1 chk("sw_hazard", bus.hazard_stall, 1);
    cycle();
    cycle();
    chk("sw_store", bus.id_is_store, 1);
    drv(1, enc(16, 4, 1, 5), 19'd205, 0, 0, 0, 0, 19'd0);
    cycle();
    drv(1, enc(8, 5, 1, 1), 19'd206, 0, 0, 0, 0, 19'd0);
    #1 chk("addi_no_hazard", bus.hazard_stall, 0);
    cycle();
    chk("addi_valid", bus.id_valid, 1);

    // stall holds, flush overrides stall
    drv(1, enc(1, 6, 1, 1 << 5), 19'd207, 0, 0, 0, 0, 19'd0);
    cycle();
    drv(1, enc(2, 2, 3, 3 << 5), 19'd208, 1, 0, 0, 0, 19'd0);
    cycle();
    chk("stall_hold_rd", bus.id_rd, 6);
    chk("stall_hold_pc", bus.id_pc, 19'd207);
    drv(1, enc(24, 1, 2, 4), 19'd209, 1, 1, 0, 0, 19'd0);
    cycle();
    chk("flush_valid", bus.id_valid, 0);
    chk("flush_branch", bus.id_is_branch, 0);

    // illegal pulse only once, suppressed by flush
    drv(1, enc(6, 0, 0, 0), 19'd210, 0, 0, 0, 0, 19'd0);
    cycle();
    chk("ill_pulse", bus.illegal, 1);
    chk("ill_bubble", bus.id_valid, 0);
    drv(0, 19'd0, 19'd211, 0, 0, 0, 0, 19'd0);
    cycle();
    chk("ill_one_cycle", bus.illegal, 0);
    drv(1, enc(6, 0, 0, 0), 19'd212, 0, 1, 0, 0, 19'd0);
    cycle();
    chk("ill_flushed", bus.illegal, 0);

    // r0 writes dropped, even on the bypass path
    drv(0, 19'd0, 19'd0, 0, 0, 1, 0, 19'h7FFFF);
    cycle();
    drv(1, enc(1, 1, 0, 0), 19'd213, 0, 0, 1, 0, 19'h7FFFF);
    cycle();
    chk("r0_rs1", bus.id_rs1_data, 0);
    chk("r0_rs2", bus.id_rs2_data, 0);
    chk("r0_valid", bus.id_valid, 1);

    // asynchronous reset mid-stream
    add3 = enc(1, 3, 1, 2 << 5);
    drv(1, add3, 19'd214, 0, 0, 0, 0, 19'd0);
    cycle();
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drv(1, add3, 19'd215, 0, 0, 0, 0, 19'd0);
    cycle();
    chk("post_rst_rs1", bus.id_rs1_data, 0);
    chk("post_rst_rs2", bus.id_rs2_data, 0);
    chk("post_rst_valid", bus.id_valid, 1);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drv($urandom_range(9, 0) < 7,
          19'((ops[$urandom_range(15, 0)] << 14) | ($urandom & 32'h3FFF)),
          19'($urandom), $urandom_range(4, 0) == 0, $urandom_range(9, 0) == 0,
          $urandom_range(1, 0) == 1, int'($urandom_range(7, 0)), 19'($urandom));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 19-bit in-order pipeline, directly downstream of the fetch stage.
- Accepts fetched pc/instruction and decodes the opcode and fields.
- Reads the 8x19 register file, with write-back bypass.
- Detects load-use hazards and registers everything into the ID/EX pipeline register that feeds execute.

Parameters:
- XLEN, 19, datapath/instruction/pc width
- NREG, 8, architectural registers (r0 hardwired zero)
- RIDX, 3, register index width (log2 NREG)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- stall_in  in  1  downstream stall; holds ID/EX register
- flush  in  1  branch taken in EX; kills current decode
- if_valid  in  1  if_pc/if_instr hold a valid fetched instruction
- if_pc  in  19  pc of fetched instruction
- if_instr  in  19  fetched instruction
- wb_we  in  1  write-back enable
- wb_rd  in  3  write-back destination
- wb_data  in  19  write-back data
- hazard_stall  out  1  combinational; stalls fetch for load-use
- id_valid  out  1  ID/EX slot holds a live instruction
- id_pc  out  19  registered pc
- id_op  out  5  registered opcode
- id_rd  out  3  destination (0 if none)
- id_rs1_data  out  19  operand 1
- id_rs2_data  out  19  operand 2
- id_imm  out  19  sign-extended immediate
- id_reg_we  out  1  instruction writes rd
- id_is_load  out  1  LW
- id_is_store  out  1  SW
- id_is_branch  out  1  BEQ/BNE/JAL
- illegal  out  1  one-cycle pulse on undefined opcode

Behaviour:
- Reset: async on rst_n low. All outputs 0; all registers 0.
- Field layout: op=[18:14], A=[13:11], B=[10:8], C=[7:5], imm8=[7:0], off11=[10:0].
- R-type (NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, ACC=31): rd=A, rs1=B, rs2=C, imm=0.
  - NOP: reg_we=0.
- ADDI=8 and LW=16: rd=A, rs1=B, imm=sext(imm8).
- SW=17, BEQ=24, BNE=25: rs2=A, rs1=B, imm=sext(imm8), reg_we=0, rd=0.
- JAL=28: rd=A, imm=sext(off11), reg_we=1, no sources.
- Any other op:
  - illegal=1 for one cycle (only if if_valid and not flush).
  - Decoded as bubble (id_valid=0).
- Writes to r0 are discarded; reads of r0 return 0.
- Register file:
  - Synchronous write on clk when wb_we and wb_rd!=0.
  - Combinational read.
  - Same-cycle bypass: if wb_we and wb_rd==rsX and rsX!=0, operand = wb_data.
- hazard_stall = if_valid & id_valid & id_is_load & id_rd!=0 & (id_rd matches a used rs1 or rs2 of the decoding instruction).
  - Unused source fields never match.
- ID/EX update each clk edge, priority order:
  1. flush: id_valid<=0, reg_we/is_* <=0. Other fields don't-care. Applies even during stall_in.
  2. stall_in: hold all ID/EX fields unchanged. hazard_stall is still reported.
  3. hazard_stall: insert bubble (id_valid<=0, control bits 0). Upstream holds the instruction, so it re-decodes next cycle.
  4. Otherwise: load decoded fields; id_valid<=if_valid & legal.
- Latency: 1 cycle from if_instr to ID/EX outputs.
- Regfile writes are never blocked by stall or flush.
- Reset mid-operation: pipeline register and regfile clear immediately; no partial state survives.

Decomposition:
- Package pipe_pkg:
  - XLEN, NREG, RIDX.
  - Opcode localparams (OP_NOP … OP_ACC).
  - Field bit positions.
  - Function sext8 and function sext11.
  - Shared with the execute stage.
- One sub-module id_regfile: 8x19, two combinational read ports with write-first bypass, one write port, async reset clear, r0 forced 0.
- Decode logic, hazard detection and the ID/EX register stay in id_stage.

Test Plan:
- Reset, then ADDI r1,r0,-3 (0x08 op, A=1, B=0, imm8=0xFD) with if_valid=1 -> next cycle id_valid=1, id_rd=1, id_imm=0x7FFFD, id_reg_we=1.
- WB writes r2=0x00123 in the same cycle that ADD r3,r2,r2 decodes -> id_rs1_data=id_rs2_data=0x00123 (bypass).
- LW r4 in ID/EX followed by ADD r5,r4,r1 -> hazard_stall=1 and one bubble (id_valid=0). Next cycle the ADD is registered with id_valid=1. SW r4 via A field also stalls; ADDI r5,r1 (no r4 use) does not.
- flush asserted while stall_in=1 and a valid BEQ is decoding -> id_valid=0 next edge; other fields are don't-care.
- Opcode 6 with if_valid=1 -> illegal pulses for exactly 1 cycle, id_valid=0. Same opcode with flush=1 -> no pulse.
- Write r0=0x7FFFF then ADD r1,r0,r0 -> operands 0. Assert rst_n low mid-stream -> all outputs 0 immediately; regfile reads 0 after release.
